zero_one_event_counter: RTL and testbench
=========================================

Name: zero_one_event_counter

Overview:
- Downstream consumer of the zero-one detector's 1-cycle match pulse (Y).
- Counts match pulses over fixed windows of WIN_LEN enabled cycles and latches each window total into a result register.
- Result is read through a valid/ready handshake; also flags threshold crossings and lost (overwritten) results.
- Sits between the detector and the monitoring/readout logic.

Parameters:
- CNT_W, 8: width of event count and result; counts saturate at 2^CNT_W-1.
- WIN_LEN, 16: window length in enabled cycles; legal range >= 2.
- THRESH, 4: alarm threshold; alarm when window total >= THRESH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at a posedge resets).
- en  in  1  counting enable; 0 freezes window and event counters.
- det  in  1  match pulse from zero-one detector; sampled every posedge.
- cnt_ready  in  1  consumer ready.
- cnt_valid  out  1  result available.
- cnt_out  out  CNT_W  window event total.
- alarm  out  1  last completed window total >= THRESH.
- overrun  out  1  sticky: an unread result was overwritten.

Behaviour:
- Reset (rst==0 at posedge): wcnt=0, ecnt=0, cnt_valid=0, cnt_out=0, alarm=0, overrun=0. Reset has priority over all events, including mid-window; the partial window is discarded.
- Count FSM (derived from en): IDLE (en=0) or COUNT (en=1).
  - COUNT: wcnt increments each cycle, 0..WIN_LEN-1, then wraps to 0.
  - det=1 adds 1 to ecnt, saturating at 2^CNT_W-1.
  - IDLE: wcnt and ecnt hold; det is ignored. No other state.
- Window end: en=1 and wcnt==WIN_LEN-1.
  - total = sat(ecnt + det), so a pulse on the last cycle is counted.
  - Next posedge: cnt_out<=total, cnt_valid<=1, alarm<=(total>=THRESH), ecnt<=0, wcnt<=0.
  - Latency: cnt_valid rises 1 cycle after the last window cycle.
- Output FSM (EMPTY: cnt_valid=0, FULL: cnt_valid=1):
  - FULL -> EMPTY on cnt_valid && cnt_ready with no simultaneous window end.
  - cnt_out is stable while FULL until accepted or overwritten.
  - Window end while FULL and cnt_ready=0: cnt_out is overwritten, cnt_valid stays 1, overrun<=1.
  - Window end while FULL and cnt_ready=1: old result is consumed, new result loaded, cnt_valid stays 1, no overrun.
  - cnt_ready while EMPTY has no effect.
- alarm: level output, updated only at window end; holds between windows and through en=0.
- overrun: cleared only by reset.
- Handshake logic keeps running while en=0; window progress is frozen.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with det=1, en=1 -> all outputs 0; wcnt=0 and ecnt=0 after rst=1.
- Basic window (defaults): en=1, cnt_ready=1, det pulses on window cycles 2, 5, 9 -> cnt_valid=1 for exactly 1 cycle, 1 cycle after cycle 15; cnt_out=3; alarm=0.
- Last-cycle pulse and alarm: pulses on cycles 1, 3, 6, 10, 15 -> cnt_out=5, alarm=1; alarm stays 1 through a following window of 0 pulses until that window ends, then 0.
- Overrun: cnt_ready=0 across two windows (2 then 7 pulses) -> cnt_out=7, cnt_valid=1, overrun=1. Raise cnt_ready for 1 cycle -> cnt_valid=0, overrun stays 1.
- Simultaneous accept/load: cnt_ready=1 on exactly the cycle a new result loads, with a result pending -> cnt_valid stays 1, new value on cnt_out, overrun=0.
- Saturation and enable: CNT_W=3, det=1 for a whole window -> cnt_out=7. Then en=0 for 10 cycles mid-window with det=1 -> pulses ignored; window end delayed by exactly 10 cycles. Reset mid-window -> next window restarts from 0.

Source files
------------

// File: rtl/zero_one_event_counter.sv
// Windowed event counter for the zero-one detector's match pulse.
// Counts det pulses over windows of WIN_LEN enabled cycles. At the end of each window the
// (saturating) total is latched into a result register offered on a valid/ready handshake.
// alarm reports whether the last completed window reached THRESH. overrun is a sticky flag
// set when an unread result is overwritten.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-low reset
//   en         counting enable; 0 freezes window progress and event count
//   det        match pulse, sampled every posedge
//   cnt_ready  consumer ready
//   cnt_valid  result available
//   cnt_out    window event total
//   alarm      last completed window total >= THRESH
//   overrun    sticky: an unread result was overwritten
module zero_one_event_counter #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_LEN = 16,
    parameter int unsigned THRESH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det,
    input  logic             cnt_ready,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_out,
    output logic             alarm,
    output logic             overrun
);

    localparam int unsigned          WcntW    = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WcntW-1:0]     WcntLast = WcntW'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]     CntMax   = '1;

    typedef enum logic {StIdle, StCount} cnt_state_e;
    typedef enum logic {StEmpty, StFull} out_state_e;

    cnt_state_e       cnt_state;
    out_state_e       out_state_q, out_state_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             alarm_q, alarm_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] ev_sum;
    logic             win_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_state_q <= StEmpty;
            wcnt_q      <= '0;
            ecnt_q      <= '0;
            cnt_out_q   <= '0;
            alarm_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            wcnt_q      <= wcnt_d;
            ecnt_q      <= ecnt_d;
            cnt_out_q   <= cnt_out_d;
            alarm_q     <= alarm_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        wcnt_d      = wcnt_q;
        ecnt_d      = ecnt_q;
        cnt_out_d   = cnt_out_q;
        alarm_d     = alarm_q;
        overrun_d   = overrun_q;

        // The count FSM has no memory of its own: its state is simply the enable.
        cnt_state = en ? StCount : StIdle;

        // Includes the current pulse so a det on the last window cycle is counted.
        ev_sum  = (det && (ecnt_q != CntMax)) ? ecnt_q + CNT_W'(1) : ecnt_q;
        win_end = (cnt_state == StCount) && (wcnt_q == WcntLast);

        case (cnt_state)
            StIdle: begin
                // Window frozen, det ignored.
            end
            StCount: begin
                if (win_end) begin
                    wcnt_d = '0;
                    ecnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q + WcntW'(1);
                    ecnt_d = ev_sum;
                end
            end
            default: ;
        endcase

        case (out_state_q)
            StEmpty: begin
                if (win_end) begin
                    out_state_d = StFull;
                end
            end
            StFull: begin
                if (win_end) begin
                    // Loading while full: with ready the old result is consumed this cycle,
                    // without ready it is lost.
                    if (!cnt_ready) begin
                        overrun_d = 1'b1;
                    end
                end else if (cnt_ready) begin
                    out_state_d = StEmpty;
                end
            end
            default: out_state_d = StEmpty;
        endcase

        if (win_end) begin
            cnt_out_d = ev_sum;
            alarm_d   = (32'(ev_sum) >= THRESH);
        end
    end

    assign cnt_valid = (out_state_q == StFull);
    assign cnt_out   = cnt_out_q;
    assign alarm     = alarm_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_zero_one_event_counter.sv
// Directed bench for zero_one_event_counter: a default instance (CNT_W=8) and a narrow
// instance (CNT_W=3) share the same stimulus.
module tb_zero_one_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       det;
    logic       cnt_ready;
    logic       cnt_valid;
    logic [7:0] cnt_out;
    logic       alarm;
    logic       overrun;
    logic       s_valid;
    logic [2:0] s_out;
    logic       s_alarm;
    logic       s_overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    zero_one_event_counter #(
        .CNT_W  (8),
        .WIN_LEN(16),
        .THRESH (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .det      (det),
        .cnt_ready(cnt_ready),
        .cnt_valid(cnt_valid),
        .cnt_out  (cnt_out),
        .alarm    (alarm),
        .overrun  (overrun)
    );

    zero_one_event_counter #(
        .CNT_W  (3),
        .WIN_LEN(16),
        .THRESH (4)
    ) u_sat (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .det      (det),
        .cnt_ready(cnt_ready),
        .cnt_valid(s_valid),
        .cnt_out  (s_out),
        .alarm    (s_alarm),
        .overrun  (s_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge, then the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive window cycles lo..hi with det taken from the pulse mask.
    task automatic run(input logic [15:0] p, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            det = p[k];
            tick();
        end
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        det       = 1'b1;
        cnt_ready = 1'b0;

        // Reset held 3 cycles with activity on the inputs.
        repeat (3) tick();
        check("rst_valid", cnt_valid, 0);
        check("rst_out", cnt_out, 0);
        check("rst_alarm", alarm, 0);
        check("rst_overrun", overrun, 0);
        check("rst_s_out", s_out, 0);
        rst       = 1'b1;
        cnt_ready = 1'b1;

        // Basic window: pulses on cycles 2, 5, 9.
        run(16'h0224, 0, 14);
        check("basic_pre_valid", cnt_valid, 0);
        run(16'h0224, 15, 15);
        check("basic_valid", cnt_valid, 1);
        check("basic_out", cnt_out, 3);
        check("basic_alarm", alarm, 0);

        // Pulses on 1, 3, 6, 10, 15; result consumed after one cycle.
        run(16'h844A, 0, 0);
        check("basic_one_cycle", cnt_valid, 0);
        run(16'h844A, 1, 15);
        check("last_valid", cnt_valid, 1);
        check("last_out", cnt_out, 5);
        check("last_alarm", alarm, 1);

        // Empty window: alarm holds until the window ends.
        run(16'h0000, 0, 14);
        check("alarm_hold", alarm, 1);
        check("alarm_hold_valid", cnt_valid, 0);
        run(16'h0000, 15, 15);
        check("alarm_clear", alarm, 0);
        check("empty_out", cnt_out, 0);
        check("empty_valid", cnt_valid, 1);

        // Ready only on the load cycle with a result pending: consume and reload.
        cnt_ready = 1'b0;
        run(16'hF000, 0, 14);
        check("sim_pre_valid", cnt_valid, 1);
        check("sim_pre_out", cnt_out, 0);
        cnt_ready = 1'b1;
        run(16'hF000, 15, 15);
        check("sim_valid", cnt_valid, 1);
        check("sim_out", cnt_out, 4);
        check("sim_alarm", alarm, 1);
        check("sim_overrun", overrun, 0);

        // Overrun: drain, then two windows unread (2 then 7 pulses).
        run(16'h0101, 0, 0);
        cnt_ready = 1'b0;
        run(16'h0101, 1, 15);
        check("ovr1_out", cnt_out, 2);
        check("ovr1_overrun", overrun, 0);
        check("ovr1_alarm", alarm, 0);
        run(16'h007F, 0, 15);
        check("ovr2_out", cnt_out, 7);
        check("ovr2_valid", cnt_valid, 1);
        check("ovr2_overrun", overrun, 1);
        cnt_ready = 1'b1;
        run(16'h0000, 0, 0);
        cnt_ready = 1'b0;
        check("ovr_read_valid", cnt_valid, 0);
        check("ovr_sticky", overrun, 1);
        run(16'h0000, 1, 1);

        // Reset mid-window clears the sticky overrun.
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        check("rst2_overrun", overrun, 0);
        check("rst2_valid", cnt_valid, 0);
        cnt_ready = 1'b1;

        // Saturation: det every cycle.
        run(16'hFFFF, 0, 15);
        check("sat_wide_out", cnt_out, 16);
        check("sat_out", s_out, 7);
        check("sat_valid", s_valid, 1);
        check("sat_alarm", s_alarm, 1);

        // Enable freeze: 5 cycles, 10 disabled cycles with det high, then the rest.
        run(16'h0060, 0, 4);
        check("en_consumed", cnt_valid, 0);
        en  = 1'b0;
        det = 1'b1;
        repeat (10) tick();
        check("en_frozen_valid", cnt_valid, 0);
        check("en_alarm_hold", alarm, 1);
        check("en_out_hold", cnt_out, 16);
        en = 1'b1;
        run(16'h0060, 5, 14);
        check("en_pre_valid", cnt_valid, 0);
        run(16'h0060, 15, 15);
        check("en_valid", cnt_valid, 1);
        check("en_out", cnt_out, 2);
        check("en_alarm", alarm, 0);
        check("en_s_out", s_out, 2);

        // Reset mid-window discards the partial window; next window restarts at 0.
        run(16'hFFFF, 0, 7);
        rst = 1'b0;
        det = 1'b1;
        tick();
        rst = 1'b1;
        check("rst3_valid", cnt_valid, 0);
        check("rst3_out", cnt_out, 0);
        run(16'h8001, 0, 14);
        check("rst3_pre_valid", cnt_valid, 0);
        run(16'h8001, 15, 15);
        check("rst3_win_valid", cnt_valid, 1);
        check("rst3_win_out", cnt_out, 2);
        check("rst3_s_out", s_out, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
